reg_wb_arbiter: RTL and testbench

//  Shares the register file's single write port (IN/INADDRESS/WRITE) between two writeback

---
 rtl/reg_wb_arbiter_if.sv | 60 ++++++
 rtl/reg_wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_reg_wb_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : reg_wb_arbiter_if                                              |
// | Purpose   : Bundles the signals of the writeback arbiter. These are the two|
// |             requester handshakes, the register-file write port, the read   |
// |             hazard inputs and the stall/forward outputs.                   |
// | Modports  : master - requesters / pipeline side (drives requests, reads)   |
// |             slave  - the arbiter itself                                    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface reg_wb_arbiter_if #(
  parameter int W  = 8,
  parameter int AW = 3
);
  // ALU writeback requester
  logic          ALU_VALID;
  logic [AW-1:0] ALU_ADDR;
  logic [W-1:0]  ALU_DATA;
  logic          ALU_READY;
  // Load writeback requester
  logic          MEM_VALID;
  logic [AW-1:0] MEM_ADDR;
  logic [W-1:0]  MEM_DATA;
  logic          MEM_READY;
  // Register file write port
  logic          WB_WRITE;
  logic [AW-1:0] WB_ADDR;
  logic [W-1:0]  WB_DATA;
  // Read ports and hazard reporting
  logic          RD1_EN;
  logic [AW-1:0] RD1_ADDR;
  logic          RD2_EN;
  logic [AW-1:0] RD2_ADDR;
  logic          STALL;
  logic          FWD1_VALID;
  logic [W-1:0]  FWD1_DATA;
  logic          FWD2_VALID;
  logic [W-1:0]  FWD2_DATA;

  modport master (
    output ALU_VALID, ALU_ADDR, ALU_DATA,
    input  ALU_READY,
    output MEM_VALID, MEM_ADDR, MEM_DATA,
    input  MEM_READY,
    input  WB_WRITE, WB_ADDR, WB_DATA,
    output RD1_EN, RD1_ADDR, RD2_EN, RD2_ADDR,
    input  STALL, FWD1_VALID, FWD1_DATA, FWD2_VALID, FWD2_DATA
  );

  modport slave (
    input  ALU_VALID, ALU_ADDR, ALU_DATA,
    output ALU_READY,
    input  MEM_VALID, MEM_ADDR, MEM_DATA,
    output MEM_READY,
    output WB_WRITE, WB_ADDR, WB_DATA,
    input  RD1_EN, RD1_ADDR, RD2_EN, RD2_ADDR,
    output STALL, FWD1_VALID, FWD1_DATA, FWD2_VALID, FWD2_DATA
  );
endinterface
`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : reg_wb_arbiter                                                 |
// | Purpose   : Shares the register file's single write port between the ALU  |
// |             and load writeback paths. Each path has a 1-entry buffer, and  |
// |             buffered writes issue oldest-first through a registered output |
// |             stage. A pending-write scoreboard flags read hazards.          |
// | Ports     : CLK, RESET (sync, active high)                                 |
// |             bus.ALU_* / bus.MEM_*  valid/ready writeback requests          |
// |             bus.WB_*               register file WRITE/INADDRESS/IN        |
// |             bus.RD1_* / bus.RD2_*  read-port enables and addresses         |
// |             bus.STALL, bus.FWD*    hazard stall and optional forwarding    |
// | Options   : REG_WB_FWD_EN - forward the youngest pending value to the      |
// |             read ports instead of stalling                                 |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module reg_wb_arbiter #(
  parameter int W  = 8,
  parameter int AW = 3,
  parameter int N  = 8
) (
  input wire              CLK,
  input wire              RESET,
  reg_wb_arbiter_if.slave bus
);

  // Requester buffers
  logic          r_alu_full;
  logic [AW-1:0] r_alu_addr;
  logic [W-1:0]  r_alu_data;
  logic          r_mem_full;
  logic [AW-1:0] r_mem_addr;
  logic [W-1:0]  r_mem_data;
  // Set when the MEM buffer was loaded before the ALU buffer. It is only
  // meaningful while both buffers are full.
  logic          r_mem_older;
  // Registered write port
  logic          r_wb_write;
  logic [AW-1:0] r_wb_addr;
  logic [W-1:0]  r_wb_data;

  logic          w_alu_acc;
  logic          w_mem_acc;
  logic          w_issue_alu;
  logic          w_issue_mem;
  logic [N-1:0]  w_pending;
  logic          w_hit1;
  logic          w_hit2;

  assign bus.ALU_READY = !RESET && !r_alu_full;
  assign bus.MEM_READY = !RESET && !r_mem_full;

  assign w_alu_acc = bus.ALU_VALID && bus.ALU_READY;
  assign w_mem_acc = bus.MEM_VALID && bus.MEM_READY;

  // The oldest full buffer wins. A lone full buffer is trivially the oldest.
  assign w_issue_alu = r_alu_full && (!r_mem_full || !r_mem_older);
  assign w_issue_mem = r_mem_full && (!r_alu_full ||  r_mem_older);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_alu_full  <= 1'b0;
      r_alu_addr  <= '0;
      r_alu_data  <= '0;
      r_mem_full  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_mem_older <= 1'b0;
      r_wb_write  <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
    end else begin
      // A buffer only accepts while empty, so accept and issue never
      // collide on the same buffer.
      if (w_alu_acc) begin
        r_alu_full <= 1'b1;
        r_alu_addr <= bus.ALU_ADDR;
        r_alu_data <= bus.ALU_DATA;
      end else if (w_issue_alu) begin
        r_alu_full <= 1'b0;
      end

      if (w_mem_acc) begin
        r_mem_full <= 1'b1;
        r_mem_addr <= bus.MEM_ADDR;
        r_mem_data <= bus.MEM_DATA;
      end else if (w_issue_mem) begin
        r_mem_full <= 1'b0;
      end

      // A lone accept makes that buffer the younger one. If the other
      // buffer is still full after this edge, it predates the new entry.
      // A simultaneous load ranks ALU as older.
      if (w_alu_acc && w_mem_acc) begin
        r_mem_older <= 1'b0;
      end else if (w_alu_acc) begin
        r_mem_older <= 1'b1;
      end else if (w_mem_acc) begin
        r_mem_older <= 1'b0;
      end

      r_wb_write <= w_issue_alu || w_issue_mem;
      if (w_issue_alu) begin
        r_wb_addr <= r_alu_addr;
        r_wb_data <= r_alu_data;
      end else if (w_issue_mem) begin
        r_wb_addr <= r_mem_addr;
        r_wb_data <= r_mem_data;
      end
    end
  end

  assign bus.WB_WRITE = r_wb_write;
  assign bus.WB_ADDR  = r_wb_addr;
  assign bus.WB_DATA  = r_wb_data;

  // The scoreboard is derived from state rather than counted, so the same
  // address held in several places clears only when the last one retires.
  for (genvar i = 0; i < N; i++) begin : g_pend
    assign w_pending[i] = (r_alu_full && (r_alu_addr == AW'(i))) ||
                          (r_mem_full && (r_mem_addr == AW'(i))) ||
                          (r_wb_write && (r_wb_addr  == AW'(i)));
  end

  assign w_hit1 = !RESET && bus.RD1_EN && w_pending[bus.RD1_ADDR];
  assign w_hit2 = !RESET && bus.RD2_EN && w_pending[bus.RD2_ADDR];

`ifdef REG_WB_FWD_EN
  // Youngest pending value for an address: the younger buffer first, then
  // the older buffer, then the output register.
  function automatic logic [W-1:0] f_youngest(input logic [AW-1:0] a);
    logic          alu_hit;
    logic          mem_hit;
    logic [W-1:0]  val;
    alu_hit = r_alu_full && (r_alu_addr == a);
    mem_hit = r_mem_full && (r_mem_addr == a);
    val     = '0;
    if (alu_hit && mem_hit) begin
      val = r_mem_older ? r_alu_data : r_mem_data;
    end else if (alu_hit) begin
      val = r_alu_data;
    end else if (mem_hit) begin
      val = r_mem_data;
    end else if (r_wb_write && (r_wb_addr == a)) begin
      val = r_wb_data;
    end
    return val;
  endfunction

  assign bus.STALL      = 1'b0;
  assign bus.FWD1_VALID = w_hit1;
  assign bus.FWD1_DATA  = w_hit1 ? f_youngest(bus.RD1_ADDR) : '0;
  assign bus.FWD2_VALID = w_hit2;
  assign bus.FWD2_DATA  = w_hit2 ? f_youngest(bus.RD2_ADDR) : '0;
`else
  assign bus.STALL      = w_hit1 || w_hit2;
  assign bus.FWD1_VALID = 1'b0;
  assign bus.FWD1_DATA  = '0;
  assign bus.FWD2_VALID = 1'b0;
  assign bus.FWD2_DATA  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_reg_wb_arbiter                                              |
// | Purpose   : Self-checking bench for reg_wb_arbiter. A queue-based model of |
// |             the buffers tracks the expected behaviour. A scoreboard of     |
// |             expected writes is filled on acceptance and drained by a       |
// |             monitor whenever the DUT drives WB_WRITE. A small register file|
// |             commits the DUT's writes.                                      |
// | Options   : REG_WB_FWD_EN - must match the RTL build                       |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_reg_wb_arbiter;

  logic CLK;
  logic RESET;

  reg_wb_arbiter_if #(.W(8), .AW(3)) bus ();

  reg_wb_arbiter #(.W(8), .AW(3), .N(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit         src;   // 0 = ALU, 1 = MEM
    logic [2:0] addr;
    logic [7:0] data;
  } ent_t;

  ent_t       m_buf[$];   // buffered writes, oldest at the front
  ent_t       exp_q[$];   // scoreboard of writes still expected on WB
  bit         m_out_v;
  logic [2:0] m_out_a;
  logic [7:0] m_out_d;
  logic [7:0] ref_rf [8];
  logic [7:0] rf     [8];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit has_src(input bit s);
    foreach (m_buf[i]) if (m_buf[i].src == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pend(input logic [2:0] a);
    foreach (m_buf[i]) if (m_buf[i].addr == a) return 1'b1;
    return m_out_v && (m_out_a == a);
  endfunction

  function automatic logic [7:0] youngest(input logic [2:0] a);
    for (int i = m_buf.size() - 1; i >= 0; i--)
      if (m_buf[i].addr == a) return m_buf[i].data;
    if (m_out_v && (m_out_a == a)) return m_out_d;
    return 8'h00;
  endfunction

  // Reference model: one write leaves the buffers per edge in acceptance
  // order, and a requester may only load while it has nothing buffered.
  initial begin
    m_out_v = 1'b0;
    m_out_a = '0;
    m_out_d = '0;
    for (int i = 0; i < 8; i++) begin
      ref_rf[i] = 8'h00;
      rf[i]     = 8'h00;
    end
    forever begin
      bit   alu_rdy;
      bit   mem_rdy;
      ent_t e;
      @(posedge CLK);
      if (m_out_v) ref_rf[m_out_a] = m_out_d;
      if (RESET) begin
        m_buf.delete();
        exp_q.delete();
        m_out_v = 1'b0;
      end else begin
        alu_rdy = !has_src(1'b0);
        mem_rdy = !has_src(1'b1);
        if (m_buf.size() > 0) begin
          e       = m_buf.pop_front();
          m_out_v = 1'b1;
          m_out_a = e.addr;
          m_out_d = e.data;
        end else begin
          m_out_v = 1'b0;
        end
        if (bus.ALU_VALID && alu_rdy) begin
          e = '{1'b0, bus.ALU_ADDR, bus.ALU_DATA};
          m_buf.push_back(e);
          exp_q.push_back(e);
        end
        if (bus.MEM_VALID && mem_rdy) begin
          e = '{1'b1, bus.MEM_ADDR, bus.MEM_DATA};
          m_buf.push_back(e);
          exp_q.push_back(e);
        end
      end
    end
  end

  // Register file fed by the DUT's write port.
  initial forever begin
    @(posedge CLK);
    if (bus.WB_WRITE === 1'b1) rf[bus.WB_ADDR] = bus.WB_DATA;
  end

  // Monitor: samples mid-cycle, away from the active edge.
  initial forever begin
    bit   h1;
    bit   h2;
    ent_t e;
    @(negedge CLK);
    #2;
    chk("alu_ready", {31'd0, bus.ALU_READY}, {31'd0, !RESET && !has_src(1'b0)});
    chk("mem_ready", {31'd0, bus.MEM_READY}, {31'd0, !RESET && !has_src(1'b1)});
    chk("wb_write",  {31'd0, bus.WB_WRITE},  {31'd0, m_out_v});
    if (bus.WB_WRITE === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("wb_addr", {29'd0, bus.WB_ADDR}, {29'd0, e.addr});
        chk("wb_data", {24'd0, bus.WB_DATA}, {24'd0, e.data});
      end
    end
    h1 = !RESET && bus.RD1_EN && pend(bus.RD1_ADDR);
    h2 = !RESET && bus.RD2_EN && pend(bus.RD2_ADDR);
`ifdef REG_WB_FWD_EN
    chk("stall",      {31'd0, bus.STALL},      32'd0);
    chk("fwd1_valid", {31'd0, bus.FWD1_VALID}, {31'd0, h1});
    chk("fwd2_valid", {31'd0, bus.FWD2_VALID}, {31'd0, h2});
    if (h1) chk("fwd1_data", {24'd0, bus.FWD1_DATA}, {24'd0, youngest(bus.RD1_ADDR)});
    if (h2) chk("fwd2_data", {24'd0, bus.FWD2_DATA}, {24'd0, youngest(bus.RD2_ADDR)});
`else
    chk("stall",      {31'd0, bus.STALL},      {31'd0, h1 || h2});
    chk("fwd1_valid", {31'd0, bus.FWD1_VALID}, 32'd0);
    chk("fwd2_valid", {31'd0, bus.FWD2_VALID}, 32'd0);
    chk("fwd1_data",  {24'd0, bus.FWD1_DATA},  32'd0);
    chk("fwd2_data",  {24'd0, bus.FWD2_DATA},  32'd0);
`endif
  end

  // Drive one cycle of inputs (called just after a falling edge).
  task automatic cyc(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                     input logic mv, input logic [2:0] ma, input logic [7:0] md,
                     input logic r1e, input logic [2:0] r1a,
                     input logic r2e, input logic [2:0] r2a);
    bus.ALU_VALID = av;
    bus.ALU_ADDR  = aa;
    bus.ALU_DATA  = ad;
    bus.MEM_VALID = mv;
    bus.MEM_ADDR  = ma;
    bus.MEM_DATA  = md;
    bus.RD1_EN    = r1e;
    bus.RD1_ADDR  = r1a;
    bus.RD2_EN    = r2e;
    bus.RD2_ADDR  = r2a;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    RESET = 1'b1;
    bus.ALU_VALID = 1'b0; bus.ALU_ADDR = '0; bus.ALU_DATA = '0;
    bus.MEM_VALID = 1'b0; bus.MEM_ADDR = '0; bus.MEM_DATA = '0;
    bus.RD1_EN = 1'b0; bus.RD1_ADDR = '0; bus.RD2_EN = 1'b0; bus.RD2_ADDR = '0;
    @(negedge CLK);
    idle(3);
    RESET = 1'b0;
    idle(1);

    // Single ALU write to r3.
    cyc(1, 3, 8'h5A, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    chk("reg3", {24'd0, rf[3]}, 32'h5A);

    // Simultaneous ALU and MEM accept, with ALU issuing first.
    cyc(1, 2, 8'h11, 1, 5, 8'h22, 0, 0, 0, 0);
    idle(4);
    chk("reg2", {24'd0, rf[2]}, 32'h11);
    chk("reg5", {24'd0, rf[5]}, 32'h22);

    // Same destination from both requesters, where the later accept wins.
    cyc(0, 0, 0, 1, 4, 8'hAA, 0, 0, 0, 0);
    cyc(1, 4, 8'hBB, 0, 0, 0, 0, 0, 0, 0);
    idle(4);
    chk("reg4", {24'd0, rf[4]}, 32'hBB);

    // Read hazard on r6, then an unrelated read of r7.
    cyc(1, 6, 8'h66, 0, 0, 0, 1, 6, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 1, 6, 0, 0);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);

    // Pending r1 in the output register with a newer r1 buffered.
    cyc(1, 1, 8'h33, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 8'h44, 0, 0, 1, 1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(2);
    chk("reg1", {24'd0, rf[1]}, 32'h44);

    // Reset while the ALU buffer holds a write, which must never issue.
    cyc(1, 0, 8'hE7, 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b1;
    idle(2);
    RESET = 1'b0;
    idle(4);
    chk("reg0", {24'd0, rf[0]}, 32'h00);

    // Random traffic, with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      RESET = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
          $urandom_range(0, 1), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
          $urandom_range(0, 1), 3'($urandom_range(0, 7)),
          $urandom_range(0, 1), 3'($urandom_range(0, 7)));
    end
    RESET = 1'b0;
    idle(6);

    chk("drain", exp_q.size(), 32'd0);
    for (int i = 0; i < 8; i++) chk("regfile", {24'd0, rf[i]}, {24'd0, ref_rf[i]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
